// File: rtl/enoc_packet_sink_pkg.sv
// Shared ENoC types and constants for the packet sink and its LFSR.
package enoc_packet_sink_pkg;

    // Ceiling log2, used for the source/destination field width.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int NODES_DEF = 16;
    localparam int LOC_DEF   = 0;

    localparam int SRC_W     = log2(NODES_DEF);
    localparam int DATA_W    = 16;
    localparam int TS_W      = 32;
    localparam int LAT_W     = 32;
    localparam int LAT_SUM_W = 48;
    localparam int ERR_CNT_W = 16;

    // Flit as delivered by the router output port; data carries the
    // per-source sequence number.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  source;
        logic [SRC_W-1:0]  dest;
        logic              valid;
        logic [TS_W-1:0]   timestamp;
        logic              measure;
    } packet_t;

endpackage

// File: rtl/enoc_packet_sink_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1), shared with the
// traffic generators. Seed must be non-zero.
module enoc_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [15:0] state
);

    logic feedback;

    // Feedback tap combination for the maximal-length polynomial.
    always_comb begin
        feedback = state[15] ^ state[13] ^ state[12] ^ state[10];
    end

    // Shift register: reload seed on reset, otherwise shift when enabled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SEED;
        end else if (enable) begin
            state <= {state[14:0], feedback};
        end
    end

endmodule

// File: rtl/enoc_packet_sink.sv
// ENoC ejection sink: drives programmable backpressure, checks sequence,
// destination and format of accepted flits, and gathers latency statistics.
// Pipeline: accept/check (stage 0) -> stage 1 register -> stats update, so a
// flit accepted in cycle n shows on the statistics outputs in cycle n+2.
module enoc_packet_sink
    import enoc_packet_sink_pkg::*;
#(
    parameter int          NODES       = NODES_DEF,
    parameter int          LOC         = LOC_DEF,
    parameter int          ACCEPT_RATE = 100,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  packet_t                i_data,
    input  logic                   i_data_val,
    output logic                   o_en,
    input  logic [TS_W-1:0]        i_time,
    input  logic                   i_clear,
    output logic [31:0]            o_rx_count,
    output logic [31:0]            o_meas_count,
    output logic [LAT_SUM_W-1:0]   o_lat_sum,
    output logic [LAT_W-1:0]       o_lat_min,
    output logic [LAT_W-1:0]       o_lat_max,
    output logic [ERR_CNT_W-1:0]   o_err_count,
    output logic                   o_err_sticky,
    output logic [log2(NODES)-1:0] o_err_source
);

    localparam int         SW       = log2(NODES);
    localparam int         THRESH   = (ACCEPT_RATE * 256) / 100;
    localparam logic [8:0] THRESH_V = 9'(THRESH);

    logic [15:0]        lfsr_state;
    logic               en_next;
    logic               acc;
    logic [SW-1:0]      src;
    logic [DATA_W-1:0]  seq_expected;
    logic               seq_err;
    logic               dest_err;
    logic               fmt_err;
    logic               flit_err;
    logic [LAT_W-1:0]   lat;

    logic [DATA_W-1:0]  exp_seq [NODES];

    logic               s1_val;
    logic               s1_err;
    logic [SW-1:0]      s1_src;
    logic               s1_meas;
    logic [LAT_W-1:0]   s1_lat;

    logic [LAT_SUM_W:0]   sum_ext;
    logic [LAT_SUM_W-1:0] lat_sum_next;
    logic [ERR_CNT_W-1:0] err_count_next;

    enoc_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (1'b1),
        .state   (lfsr_state)
    );

    // Backpressure decision: full rate is constant enable, otherwise the
    // low LFSR byte is compared against the scaled rate threshold.
    always_comb begin
        en_next = (ACCEPT_RATE == 100) ? 1'b1 : ({1'b0, lfsr_state[7:0]} < THRESH_V);
    end

    // Registered enable towards the router; low while in reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_en <= 1'b0;
        end else begin
            o_en <= en_next;
        end
    end

    // Stage 0 checks; several simultaneous faults collapse into one flag.
    always_comb begin
        acc          = i_data_val & o_en;
        src          = SW'(i_data.source);
        seq_expected = exp_seq[src];
        seq_err      = (i_data.data != seq_expected);
        dest_err     = (i_data.dest != SRC_W'(LOC));
        fmt_err      = ~i_data.valid;
        flit_err     = seq_err | dest_err | fmt_err;
        lat          = i_time - i_data.timestamp;
    end

    // Sequence table: always resync to data+1 so one gap costs one error.
    // A write in cycle n is read by the check in cycle n+1 directly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NODES; i++) begin
                exp_seq[i] <= DATA_W'(1);
            end
        end else if (acc) begin
            exp_seq[src] <= i_data.data + DATA_W'(1);
        end
    end

    // Stage 1 register: capture check result and latency of accepted flit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_val  <= 1'b0;
            s1_err  <= 1'b0;
            s1_src  <= '0;
            s1_meas <= 1'b0;
            s1_lat  <= '0;
        end else begin
            s1_val <= acc;
            if (acc) begin
                s1_err  <= flit_err;
                s1_src  <= src;
                s1_meas <= i_data.measure;
                s1_lat  <= lat;
            end
        end
    end

    // Saturating next values for the latency sum and the error counter.
    always_comb begin
        sum_ext        = (LAT_SUM_W+1)'(o_lat_sum) + (LAT_SUM_W+1)'(s1_lat);
        lat_sum_next   = sum_ext[LAT_SUM_W] ? '1 : sum_ext[LAT_SUM_W-1:0];
        err_count_next = (o_err_count == '1) ? o_err_count
                                             : o_err_count + ERR_CNT_W'(1);
    end

    // Stage 2 statistics update; clear takes priority and drops the
    // stage-1 flit. err_source is diagnostic and survives a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_rx_count   <= '0;
            o_meas_count <= '0;
            o_lat_sum    <= '0;
            o_lat_min    <= '1;
            o_lat_max    <= '0;
            o_err_count  <= '0;
            o_err_sticky <= 1'b0;
            o_err_source <= '0;
        end else if (i_clear) begin
            o_rx_count   <= '0;
            o_meas_count <= '0;
            o_lat_sum    <= '0;
            o_lat_min    <= '1;
            o_lat_max    <= '0;
            o_err_count  <= '0;
            o_err_sticky <= 1'b0;
        end else if (s1_val) begin
            o_rx_count <= o_rx_count + 32'd1;
            if (s1_meas) begin
                o_meas_count <= o_meas_count + 32'd1;
                o_lat_sum    <= lat_sum_next;
                if (s1_lat < o_lat_min) begin
                    o_lat_min <= s1_lat;
                end
                if (s1_lat > o_lat_max) begin
                    o_lat_max <= s1_lat;
                end
            end
            if (s1_err) begin
                o_err_count  <= err_count_next;
                o_err_sticky <= 1'b1;
                o_err_source <= s1_src;
            end
        end
    end

endmodule

// File: tb/tb_enoc_packet_sink.sv
// Bench for enoc_packet_sink: directed flits with a scoreboard of expected
// statistics snapshots, plus hand-computed end-of-test checks.
module tb_enoc_packet_sink;
    import enoc_packet_sink_pkg::*;

    typedef struct packed {
        logic [31:0] rx;
        logic [31:0] meas;
        logic [47:0] sum;
        logic [31:0] mn;
        logic [31:0] mx;
        logic [15:0] errc;
        logic        sticky;
        logic [3:0]  errsrc;
    } snap_t;

    logic        clk;
    logic        reset_n;
    packet_t     pkt;
    logic        val;
    logic        val50;
    logic        clr;
    logic [31:0] tnow;

    logic        o_en;
    logic [31:0] rx, meas_c, lmin, lmax;
    logic [47:0] lsum;
    logic [15:0] errc;
    logic        sticky;
    logic [3:0]  errsrc;

    logic        o_en50;
    logic [31:0] rx50, meas50, lmin50, lmax50;
    logic [47:0] lsum50;
    logic [15:0] errc50;
    logic        sticky50;
    logic [3:0]  errsrc50;

    int    n_cmp = 0;
    int    n_bad = 0;
    snap_t q[$];
    snap_t m;
    logic [15:0] mseq [16];
    logic  pipe0, pipe1;

    enoc_packet_sink #(.NODES(16), .LOC(0), .ACCEPT_RATE(100), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset_n(reset_n), .i_data(pkt), .i_data_val(val), .o_en(o_en),
        .i_time(tnow), .i_clear(clr), .o_rx_count(rx), .o_meas_count(meas_c),
        .o_lat_sum(lsum), .o_lat_min(lmin), .o_lat_max(lmax), .o_err_count(errc),
        .o_err_sticky(sticky), .o_err_source(errsrc));

    enoc_packet_sink #(.NODES(16), .LOC(0), .ACCEPT_RATE(50), .LFSR_SEED(16'hACE1)) dut50 (
        .clk(clk), .reset_n(reset_n), .i_data(pkt), .i_data_val(val50), .o_en(o_en50),
        .i_time(tnow), .i_clear(clr), .o_rx_count(rx50), .o_meas_count(meas50),
        .o_lat_sum(lsum50), .o_lat_min(lmin50), .o_lat_max(lmax50), .o_err_count(errc50),
        .o_err_sticky(sticky50), .o_err_source(errsrc50));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tnow = 32'd100;
    always @(posedge clk) tnow <= tnow + 32'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m.rx = 0; m.meas = 0; m.sum = 0; m.mn = '1; m.mx = 0;
        m.errc = 0; m.sticky = 0; m.errsrc = 0;
        for (int i = 0; i < 16; i++) mseq[i] = 16'd1;
    endtask

    task automatic model_clear();
        m.rx = 0; m.meas = 0; m.sum = 0; m.mn = '1; m.mx = 0;
        m.errc = 0; m.sticky = 0;
    endtask

    // Drive one flit for one cycle and push the expected stats snapshot.
    task automatic send(input int src, input logic [15:0] data, input int dst,
                        input bit vld, input bit meas, input logic [31:0] lat,
                        input bit clr_after);
        bit err;
        logic [48:0] s;
        logic [3:0] s4, d4;
        s4 = src[3:0];
        d4 = dst[3:0];
        @(posedge clk); #1;
        pkt.data = data; pkt.source = s4; pkt.dest = d4; pkt.valid = vld;
        pkt.timestamp = tnow - lat; pkt.measure = meas;
        val = 1'b1; clr = 1'b0;
        err = (data != mseq[src]) || (dst != 0) || !vld;
        mseq[src] = data + 16'd1;
        m.rx = m.rx + 1;
        if (meas) begin
            m.meas = m.meas + 1;
            s = {1'b0, m.sum} + {17'b0, lat};
            m.sum = s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
            if (lat < m.mn) m.mn = lat;
            if (lat > m.mx) m.mx = lat;
        end
        if (err) begin
            if (m.errc != 16'hFFFF) m.errc = m.errc + 1;
            m.sticky = 1'b1;
            m.errsrc = s4;
        end
        if (clr_after) model_clear();
        q.push_back(m);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            val = 1'b0; clr = 1'b0;
        end
    endtask

    // Monitor: each accepted flit shows on the outputs two cycles later.
    always @(negedge clk) begin
        snap_t got, e;
        got = '{rx: rx, meas: meas_c, sum: lsum, mn: lmin, mx: lmax,
                errc: errc, sticky: sticky, errsrc: errsrc};
        if (pipe1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: actual %h required none", got);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard_snapshot: actual %h required %h", got, e);
                end
            end
        end
        pipe1 = pipe0;
        pipe0 = reset_n & val & o_en;
        if (!reset_n) begin
            pipe0 = 1'b0;
            pipe1 = 1'b0;
            q.delete();
        end
    end

    initial begin
        int cnt;
        bit seen;
        pipe0 = 0; pipe1 = 0;
        reset_n = 1'b0; val = 1'b0; val50 = 1'b0; clr = 1'b0; pkt = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", 64'(o_en), 0);
        chk("rst_en50", 64'(o_en50), 0);
        chk("rst_rx", 64'(rx), 0);
        chk("rst_min", 64'(lmin), 64'hFFFF_FFFF);
        chk("rst_max", 64'(lmax), 0);
        chk("rst_sum", 64'(lsum), 0);
        chk("rst_errc", 64'(errc), 0);
        chk("rst_sticky", 64'(sticky), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);

        // 50% backpressure duty and acceptance count
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            val50 = 1'b1;
            @(negedge clk);
            if (o_en50) cnt++;
        end
        @(posedge clk); #1;
        val50 = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rate50_rx_eq_en_cycles", 64'(rx50), 64'(cnt));
        chk("rate50_duty_45_55", 64'((cnt >= 900 && cnt <= 1100) ? 1 : 0), 1);

        // in-order measured flits, latency 4
        send(2, 16'd1, 0, 1, 1, 32'd4, 0);
        send(2, 16'd2, 0, 1, 1, 32'd4, 0);
        send(2, 16'd3, 0, 1, 1, 32'd4, 0);
        idle(3);
        @(negedge clk);
        chk("t1_rx", 64'(rx), 3);
        chk("t1_meas", 64'(meas_c), 3);
        chk("t1_min", 64'(lmin), 4);
        chk("t1_max", 64'(lmax), 4);
        chk("t1_sum", 64'(lsum), 12);
        chk("t1_errc", 64'(errc), 0);
        chk("t1_sticky", 64'(sticky), 0);

        // sequence gap with resync, unmeasured flits
        send(1, 16'd1, 0, 1, 0, 32'd0, 0);
        send(1, 16'd2, 0, 1, 0, 32'd0, 0);
        send(1, 16'd4, 0, 1, 0, 32'd0, 0);
        send(1, 16'd5, 0, 1, 0, 32'd0, 0);
        idle(3);
        @(negedge clk);
        chk("t2_errc", 64'(errc), 1);
        chk("t2_errsrc", 64'(errsrc), 1);
        chk("t2_sticky", 64'(sticky), 1);
        chk("t2_rx", 64'(rx), 7);
        chk("t2_meas", 64'(meas_c), 3);

        // wrong dest, then in-order flit; format error; multi-fault flit
        send(0, 16'd1, 1, 1, 1, 32'd10, 0);
        send(0, 16'd2, 0, 1, 1, 32'd10, 0);
        idle(3);
        @(negedge clk);
        chk("t3_errc", 64'(errc), 2);
        chk("t3_errsrc", 64'(errsrc), 0);
        chk("t3_rx", 64'(rx), 9);
        chk("t3_sum", 64'(lsum), 32);
        chk("t3_max", 64'(lmax), 10);
        chk("t3_min", 64'(lmin), 4);
        send(6, 16'd1, 0, 0, 0, 32'd0, 0);
        send(7, 16'd5, 2, 0, 0, 32'd0, 0);
        idle(3);
        @(negedge clk);
        chk("t3_fmt_multi_errc", 64'(errc), 4);
        chk("t3_fmt_multi_errsrc", 64'(errsrc), 7);

        // clear colliding with the stage-2 update of the fifth flit
        for (int d = 1; d <= 5; d++) send(3, 16'(d), 0, 1, 1, 32'd6, d == 5);
        @(posedge clk); #1;
        val = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        idle(2);
        @(negedge clk);
        chk("t5_rx", 64'(rx), 0);
        chk("t5_meas", 64'(meas_c), 0);
        chk("t5_min", 64'(lmin), 64'hFFFF_FFFF);
        chk("t5_max", 64'(lmax), 0);
        chk("t5_sum", 64'(lsum), 0);
        chk("t5_errc", 64'(errc), 0);
        chk("t5_sticky", 64'(sticky), 0);
        send(3, 16'd6, 0, 1, 1, 32'd6, 0);
        idle(3);
        @(negedge clk);
        chk("t5_after_rx", 64'(rx), 1);
        chk("t5_after_errc", 64'(errc), 0);
        chk("t5_after_min", 64'(lmin), 6);

        // one-cycle reset mid-burst
        send(4, 16'd1, 0, 1, 1, 32'd3, 0);
        send(4, 16'd2, 0, 1, 1, 32'd3, 0);
        @(posedge clk); #1;
        val = 1'b0; reset_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_en_low", 64'(o_en), 0);
        chk("t6_rx", 64'(rx), 0);
        chk("t6_min", 64'(lmin), 64'hFFFF_FFFF);
        chk("t6_errsrc", 64'(errsrc), 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (o_en) seen = 1;
        end
        chk("t6_en_returns", 64'(seen), 1);
        send(4, 16'd1, 0, 1, 0, 32'd0, 0);
        send(5, 16'd1, 0, 1, 1, 32'hFFFF_FFFE, 0);
        idle(3);
        @(negedge clk);
        chk("t6_after_rx", 64'(rx), 2);
        chk("t6_after_meas", 64'(meas_c), 1);
        chk("t6_wrap_min", 64'(lmin), 64'hFFFF_FFFE);
        chk("t6_wrap_max", 64'(lmax), 64'hFFFF_FFFE);
        chk("t6_wrap_sum", 64'(lsum), 64'hFFFF_FFFE);
        chk("t6_after_errc", 64'(errc), 0);

        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
